fp_alu_sequencer: RTL and testbench



---
 rtl/fp_alu_sequencer.sv | 141 ++++++++++++++
 tb/tb_fp_alu_sequencer.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_alu_sequencer.sv
// rtl/fp_alu_sequencer.sv - command/response sequencer around a combinational FP ALU (optional FP_STICKY_FLAGS_EN)
module fp_alu_sequencer #(
    parameter int SETTLE_CYCLES = 2,
    parameter int TAG_W         = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [31:0]      cmd_a,
    input  logic [31:0]      cmd_b,
    input  logic [1:0]       cmd_op,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [1:0]       alu_op,
    input  logic [31:0]      alu_result,
    input  logic             alu_exception,
    input  logic             alu_overflow,
    input  logic             alu_underflow,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic [2:0]       rsp_flags,
    output logic [TAG_W-1:0] rsp_tag,
`ifdef FP_STICKY_FLAGS_EN
    input  logic             sticky_clr,
    output logic [2:0]       sticky_flags,
`endif
    output logic             busy
);

    generate
        if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
            $error("SETTLE_CYCLES must be in 1..15");
        end
    endgenerate

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [3:0]       count;
    logic [TAG_W-1:0] tag_q;
    logic             accept;
    logic             capture;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state and handshake outputs; every output depends on state only
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        capture    = 1'b0;
        cmd_ready  = 1'b0;
        rsp_valid  = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    accept     = 1'b1;
                    next_state = SETTLE;
                end
            end
            SETTLE: begin
                if (count == 4'd0) begin
                    capture    = 1'b1;
                    next_state = DONE;
                end
            end
            DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Settle counter: loaded on accept, counts down to the capture edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                count <= 4'd0;
        else if (accept)                        count <= SETTLE_LOAD;
        else if (state == SETTLE && count != 0) count <= count - 4'd1;
    end

    // Operand launch registers; they keep the last operands between commands
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a  <= 32'd0;
            alu_b  <= 32'd0;
            alu_op <= 2'b00;
            tag_q  <= '0;
        end else if (accept) begin
            alu_a  <= cmd_a;
            alu_b  <= cmd_b;
            alu_op <= cmd_op;
            tag_q  <= cmd_tag;
        end
    end

    // Response capture once the ALU has settled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_result <= 32'd0;
            rsp_flags  <= 3'b000;
            rsp_tag    <= '0;
        end else if (capture) begin
            rsp_result <= alu_result;
            rsp_flags  <= {alu_exception, alu_overflow, alu_underflow};
            rsp_tag    <= tag_q;
        end
    end

`ifdef FP_STICKY_FLAGS_EN
    // Sticky flag accumulator; a clear coinciding with capture leaves just the new flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_flags <= 3'b000;
        end else if (sticky_clr) begin
            sticky_flags <= capture ? {alu_exception, alu_overflow, alu_underflow} : 3'b000;
        end else if (capture) begin
            sticky_flags <= sticky_flags | {alu_exception, alu_overflow, alu_underflow};
        end
    end
`endif

endmodule

// File: tb/tb_fp_alu_sequencer.sv
// tb/tb_fp_alu_sequencer.sv - scoreboard bench for fp_alu_sequencer
module tb_fp_alu_sequencer;

    localparam int S  = 2;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [31:0]   cmd_a;
    logic [31:0]   cmd_b;
    logic [1:0]    cmd_op;
    logic [TW-1:0] cmd_tag;
    logic [31:0]   alu_a;
    logic [31:0]   alu_b;
    logic [1:0]    alu_op;
    logic [31:0]   alu_result;
    logic          alu_exception;
    logic          alu_overflow;
    logic          alu_underflow;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_result;
    logic [2:0]    rsp_flags;
    logic [TW-1:0] rsp_tag;
    logic          busy;
`ifdef FP_STICKY_FLAGS_EN
    logic          sticky_clr;
    logic [2:0]    sticky_flags;
`endif

    logic [31:0]   perturb;
    int            vectors = 0;
    int            miscompares = 0;
    int            cyc = 0;

    typedef struct packed {
        logic [TW-1:0] tag;
        logic [31:0]   result;
        logic [2:0]    flags;
    } exp_t;

    exp_t exp_q[$];

    fp_alu_sequencer #(.SETTLE_CYCLES(S), .TAG_W(TW)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_tag(cmd_tag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_exception(alu_exception),
        .alu_overflow(alu_overflow), .alu_underflow(alu_underflow),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_tag(rsp_tag),
`ifdef FP_STICKY_FLAGS_EN
        .sticky_clr(sticky_clr), .sticky_flags(sticky_flags),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Behavioural ALU stub: fixed result/flags per opcode, optionally disturbed
    always_comb begin
        alu_result = 32'd0;
        {alu_exception, alu_overflow, alu_underflow} = 3'b000;
        case (alu_op)
            2'b00: begin alu_result = 32'h4161999A; {alu_exception, alu_overflow, alu_underflow} = 3'b000; end
            2'b01: begin alu_result = 32'hC0000000; {alu_exception, alu_overflow, alu_underflow} = 3'b001; end
            2'b10: begin alu_result = 32'h7F800000; {alu_exception, alu_overflow, alu_underflow} = 3'b010; end
            2'b11: begin alu_result = 32'h3F8CCCCD; {alu_exception, alu_overflow, alu_underflow} = 3'b100; end
            default: ;
        endcase
        alu_result = alu_result ^ perturb;
    end

    function automatic exp_t model(input logic [1:0] op, input logic [TW-1:0] tag);
        exp_t e;
        e.tag = tag;
        case (op)
            2'b00:   begin e.result = 32'h4161999A; e.flags = 3'b000; end
            2'b01:   begin e.result = 32'hC0000000; e.flags = 3'b001; end
            2'b10:   begin e.result = 32'h7F800000; e.flags = 3'b010; end
            default: begin e.result = 32'h3F8CCCCD; e.flags = 3'b100; end
        endcase
        return e;
    endfunction

    function automatic exp_t pop_exp();
        exp_t e;
        e = 'x;
        if (exp_q.size() != 0) e = exp_q.pop_front();
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] op, input logic [TW-1:0] tag);
        cmd_a = a; cmd_b = b; cmd_op = op; cmd_tag = tag;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (rsp_valid !== 1'b1 && n < 40) begin
            step();
            n++;
        end
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0; cmd_tag = '0;
        rsp_ready = 1'b0; perturb = '0;
`ifdef FP_STICKY_FLAGS_EN
        sticky_clr = 1'b0;
`endif
        repeat (3) step();
        rst = 1'b0;
        step();
        vectors++;
        if ({cmd_ready, rsp_valid, busy} !== 3'b100) begin
            miscompares++;
            $display("FAIL reset_hs: got ready/valid/busy=%b expected 100", {cmd_ready, rsp_valid, busy});
        end
        vectors++;
        if ({alu_a, alu_b, alu_op, rsp_result, rsp_flags, rsp_tag} !== '0) begin
            miscompares++;
            $display("FAIL reset_regs: got alu_a=%h alu_b=%h op=%b res=%h flags=%b tag=%h expected all zero",
                     alu_a, alu_b, alu_op, rsp_result, rsp_flags, rsp_tag);
        end
`ifdef FP_STICKY_FLAGS_EN
        vectors++;
        if (sticky_flags !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_sticky: got %b expected 000", sticky_flags);
        end
`endif
        for (int i = 0; i < 10; i++) begin
            step();
            vectors++;
            if ({cmd_ready, rsp_valid, busy, alu_a} !== {3'b100, 32'd0}) begin
                miscompares++;
                $display("FAIL idle_hold: cycle %0d got ready/valid/busy=%b alu_a=%h expected 100 / 0",
                         i, {cmd_ready, rsp_valid, busy}, alu_a);
            end
        end
    endtask

    task automatic test_add();
        int   n;
        exp_t e;
        exp_q.push_back(model(2'b00, 4'd3));
        issue(32'h411CCCCD, 32'h4089999A, 2'b00, 4'd3);
        vectors++;
        if ({alu_a, alu_b, alu_op} !== {32'h411CCCCD, 32'h4089999A, 2'b00}) begin
            miscompares++;
            $display("FAIL add_launch: got a=%h b=%h op=%b expected 411ccccd 4089999a 00", alu_a, alu_b, alu_op);
        end
        vectors++;
        if ({cmd_ready, rsp_valid, busy} !== 3'b001) begin
            miscompares++;
            $display("FAIL add_settle_hs: got ready/valid/busy=%b expected 001", {cmd_ready, rsp_valid, busy});
        end
        wait_rsp(n);
        vectors++;
        if (n != S) begin
            miscompares++;
            $display("FAIL add_latency: got %0d edges expected %0d", n, S);
        end
        e = pop_exp();
        vectors++;
        if ({rsp_tag, rsp_result, rsp_flags} !== {e.tag, e.result, e.flags}) begin
            miscompares++;
            $display("FAIL add_rsp: got tag=%h res=%h flags=%b expected tag=%h res=%h flags=%b",
                     rsp_tag, rsp_result, rsp_flags, e.tag, e.result, e.flags);
        end
        consume();
        vectors++;
        if ({rsp_valid, cmd_ready, busy} !== 3'b010) begin
            miscompares++;
            $display("FAIL add_release: got valid/ready/busy=%b expected 010", {rsp_valid, cmd_ready, busy});
        end
    endtask

    task automatic test_backpressure();
        int   n;
        exp_t e;
        exp_q.push_back(model(2'b11, 4'd5));
        issue(32'h411CCCCD, 32'h4089999A, 2'b11, 4'd5);
        cmd_a = 32'hDEADBEEF; cmd_b = 32'h12345678; cmd_op = 2'b01; cmd_tag = 4'd9;
        cmd_valid = 1'b1;
        wait_rsp(n);
        vectors++;
        if (n != S) begin
            miscompares++;
            $display("FAIL bp_latency: got %0d edges expected %0d", n, S);
        end
        e = pop_exp();
        vectors++;
        if ({rsp_tag, rsp_result, rsp_flags} !== {e.tag, e.result, e.flags}) begin
            miscompares++;
            $display("FAIL bp_rsp: got tag=%h res=%h flags=%b expected tag=%h res=%h flags=%b",
                     rsp_tag, rsp_result, rsp_flags, e.tag, e.result, e.flags);
        end
        for (int i = 0; i < 5; i++) begin
            perturb   = $urandom | 32'h1;
            cmd_valid = i[0];
            cmd_tag   = 4'(i);
            step();
            vectors++;
            if ({rsp_valid, cmd_ready, rsp_tag, rsp_result, rsp_flags, alu_a, alu_op} !==
                {2'b10, e.tag, e.result, e.flags, 32'h411CCCCD, 2'b11}) begin
                miscompares++;
                $display("FAIL bp_hold: cycle %0d got valid/ready=%b tag=%h res=%h flags=%b alu_a=%h op=%b expected 10 %h %h %b 411ccccd 11",
                         i, {rsp_valid, cmd_ready}, rsp_tag, rsp_result, rsp_flags, alu_a, alu_op,
                         e.tag, e.result, e.flags);
            end
        end
        cmd_valid = 1'b0;
        perturb   = '0;
        consume();
        vectors++;
        if ({rsp_valid, cmd_ready, alu_a} !== {2'b01, 32'h411CCCCD}) begin
            miscompares++;
            $display("FAIL bp_release: got valid/ready=%b alu_a=%h expected 01 411ccccd", {rsp_valid, cmd_ready}, alu_a);
        end
    endtask

    task automatic test_overflow();
        int   n;
        exp_t e;
        exp_q.push_back(model(2'b10, 4'd9));
        issue(32'h7F000000, 32'h40000000, 2'b10, 4'd9);
        wait_rsp(n);
        e = pop_exp();
        vectors++;
        if ({rsp_tag, rsp_result, rsp_flags} !== {e.tag, e.result, e.flags} || rsp_flags !== 3'b010) begin
            miscompares++;
            $display("FAIL ovf_rsp: got tag=%h res=%h flags=%b expected tag=%h res=%h flags=010",
                     rsp_tag, rsp_result, rsp_flags, e.tag, e.result);
        end
`ifdef FP_STICKY_FLAGS_EN
        vectors++;
        if (sticky_flags !== 3'b010) begin
            miscompares++;
            $display("FAIL sticky_set: got %b expected 010", sticky_flags);
        end
`endif
        consume();
        exp_q.push_back(model(2'b00, 4'd1));
        issue(32'h3F800000, 32'h3F800000, 2'b00, 4'd1);
        wait_rsp(n);
        e = pop_exp();
        vectors++;
        if ({rsp_tag, rsp_result, rsp_flags} !== {e.tag, e.result, e.flags}) begin
            miscompares++;
            $display("FAIL clean_add_rsp: got tag=%h res=%h flags=%b expected tag=%h res=%h flags=%b",
                     rsp_tag, rsp_result, rsp_flags, e.tag, e.result, e.flags);
        end
`ifdef FP_STICKY_FLAGS_EN
        vectors++;
        if (sticky_flags !== 3'b010) begin
            miscompares++;
            $display("FAIL sticky_persist: got %b expected 010", sticky_flags);
        end
`endif
        consume();
`ifdef FP_STICKY_FLAGS_EN
        sticky_clr = 1'b1;
        step();
        sticky_clr = 1'b0;
        vectors++;
        if (sticky_flags !== 3'b000) begin
            miscompares++;
            $display("FAIL sticky_clr: got %b expected 000", sticky_flags);
        end
`endif
    endtask

    task automatic test_reset_mid();
        int   n;
        exp_t e;
        issue(32'h40400000, 32'h40800000, 2'b00, 4'd4);
        step();
        rst = 1'b1;
        #1;
        vectors++;
        if ({busy, rsp_valid, cmd_ready} !== 3'b001) begin
            miscompares++;
            $display("FAIL rst_mid_async: got busy/valid/ready=%b expected 001", {busy, rsp_valid, cmd_ready});
        end
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            vectors++;
            if ({rsp_valid, busy} !== 2'b00) begin
                miscompares++;
                $display("FAIL rst_mid_quiet: cycle %0d got valid/busy=%b expected 00", i, {rsp_valid, busy});
            end
        end
        vectors++;
        if (alu_a !== 32'd0) begin
            miscompares++;
            $display("FAIL rst_mid_alu: got alu_a=%h expected 0", alu_a);
        end
        exp_q.push_back(model(2'b01, 4'd7));
        issue(32'h40A00000, 32'h40E00000, 2'b01, 4'd7);
        wait_rsp(n);
        vectors++;
        if (n != S) begin
            miscompares++;
            $display("FAIL rst_mid_latency: got %0d edges expected %0d", n, S);
        end
        e = pop_exp();
        vectors++;
        if ({rsp_tag, rsp_result, rsp_flags} !== {e.tag, e.result, e.flags}) begin
            miscompares++;
            $display("FAIL rst_mid_rsp: got tag=%h res=%h flags=%b expected tag=%h res=%h flags=%b",
                     rsp_tag, rsp_result, rsp_flags, e.tag, e.result, e.flags);
        end
        consume();
    endtask

    task automatic test_back_to_back();
        rsp_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    int g;
                    cmd_a = 32'h3F800000 + 32'(i); cmd_b = 32'h40000000 + 32'(i);
                    cmd_op = 2'(i); cmd_tag = 4'(8 + i);
                    cmd_valid = 1'b1;
                    g = 0;
                    while (cmd_ready !== 1'b1 && g < 40) begin
                        step();
                        g++;
                    end
                    exp_q.push_back(model(2'(i), 4'(8 + i)));
                    step();
                end
                cmd_valid = 1'b0;
            end
            begin
                int prev;
                prev = 0;
                for (int k = 0; k < 4; k++) begin
                    int   g;
                    exp_t e;
                    g = 0;
                    while (rsp_valid !== 1'b1 && g < 60) begin
                        step();
                        g++;
                    end
                    vectors++;
                    if (rsp_valid !== 1'b1) begin
                        miscompares++;
                        $display("FAIL b2b_timeout: response %0d got rsp_valid=%b expected 1", k, rsp_valid);
                    end
                    e = pop_exp();
                    vectors++;
                    if ({rsp_tag, rsp_result, rsp_flags} !== {e.tag, e.result, e.flags}) begin
                        miscompares++;
                        $display("FAIL b2b_rsp: response %0d got tag=%h res=%h flags=%b expected tag=%h res=%h flags=%b",
                                 k, rsp_tag, rsp_result, rsp_flags, e.tag, e.result, e.flags);
                    end
                    if (k > 0) begin
                        vectors++;
                        if (cyc - prev != S + 2) begin
                            miscompares++;
                            $display("FAIL b2b_spacing: response %0d got %0d cycles expected %0d", k, cyc - prev, S + 2);
                        end
                    end
                    prev = cyc;
                    step();
                end
            end
        join
        rsp_ready = 1'b0;
        step();
        vectors++;
        if ({rsp_valid, cmd_ready, busy} !== 3'b010 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL b2b_drain: got valid/ready/busy=%b pending=%0d expected 010 / 0",
                     {rsp_valid, cmd_ready, busy}, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_backpressure();
        test_overflow();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
